// File: rtl/control_register_staged_if.sv
// Microstore-to-datapath bus for the staged control register.
// The master drives microstore words and pipeline controls; the slave returns the output stage.
interface control_register_staged_if #(
  parameter int unsigned WORD_WIDTH  = 38,
  parameter int unsigned STATE_WIDTH = 10,
  parameter int unsigned CNT_WIDTH   = 8
);
  logic [WORD_WIDTH-1:0]  in;
  logic [STATE_WIDTH-1:0] in_state;
  logic                   in_valid;
  logic                   stall;
  logic                   flush;
  logic                   moc;
  logic [WORD_WIDTH-1:0]  cr;
  logic [STATE_WIDTH-1:0] cr_state;
  logic                   cr_valid;
  logic                   busy;
  logic [CNT_WIDTH-1:0]   wait_cycles;

  modport master (
    output in, in_state, in_valid, stall, flush, moc,
    input  cr, cr_state, cr_valid, busy, wait_cycles
  );

  modport slave (
    input  in, in_state, in_valid, stall, flush, moc,
    output cr, cr_state, cr_valid, busy, wait_cycles
  );
endinterface

// File: rtl/control_register_staged.sv
// Pipelined microinstruction control register with stall, flush-to-NOP and a
// memory-operation wait that freezes the pipe until MOC while the output word requests memory.
module control_register_staged #(
  parameter int unsigned          WORD_WIDTH  = 38,
  parameter int unsigned          STATE_WIDTH = 10,
  parameter int unsigned          STAGES      = 1,
  parameter int unsigned          WAIT_BIT    = 30,
  parameter logic [WORD_WIDTH-1:0] NOP_WORD   = '0,
  parameter int unsigned          CNT_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  control_register_staged_if.slave  bus
);

  localparam int unsigned LAST = STAGES - 1;

  if (WAIT_BIT >= WORD_WIDTH) begin : g_bad_wait_bit
    $error("control_register_staged: WAIT_BIT must be below WORD_WIDTH");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("control_register_staged: STAGES must be in 1..4");
  end

  logic [WORD_WIDTH-1:0]  word_q  [STAGES];
  logic [WORD_WIDTH-1:0]  word_d  [STAGES];
  logic [STATE_WIDTH-1:0] state_q [STAGES];
  logic [STATE_WIDTH-1:0] state_d [STAGES];
  logic                   valid_q [STAGES];
  logic                   valid_d [STAGES];
  logic [CNT_WIDTH-1:0]   wait_q;
  logic [CNT_WIDTH-1:0]   wait_d;

  logic wait_hold_c;
  logic advance_c;

  // An invalid output stage never waits, whatever its stored word holds.
  assign wait_hold_c = valid_q[LAST] & word_q[LAST][WAIT_BIT] & ~bus.moc;
  assign advance_c   = ~bus.stall & ~wait_hold_c;

  // Next-state: flush beats advance beats hold.
  always_comb begin
    word_d  = word_q;
    state_d = state_q;
    valid_d = valid_q;
    wait_d  = '0;
    if (wait_hold_c) begin
      wait_d = (&wait_q) ? wait_q : wait_q + CNT_WIDTH'(1);
    end
    if (advance_c) begin
      word_d[0]  = bus.in;
      state_d[0] = bus.in_state;
      valid_d[0] = bus.in_valid;
      for (int unsigned i = 1; i < STAGES; i++) begin
        word_d[i]  = word_q[i-1];
        state_d[i] = state_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
    if (bus.flush) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        word_d[i]  = NOP_WORD;
        state_d[i] = '0;
        valid_d[i] = 1'b0;
      end
      wait_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        word_q[i]  <= NOP_WORD;
        state_q[i] <= '0;
        valid_q[i] <= 1'b0;
      end
      wait_q <= '0;
    end else begin
      word_q  <= word_d;
      state_q <= state_d;
      valid_q <= valid_d;
      wait_q  <= wait_d;
    end
  end

  // Output stage is masked to NOP whenever it is not a real microinstruction.
  assign bus.cr          = valid_q[LAST] ? word_q[LAST]  : NOP_WORD;
  assign bus.cr_state    = valid_q[LAST] ? state_q[LAST] : '0;
  assign bus.cr_valid    = valid_q[LAST];
  assign bus.busy        = wait_hold_c;
  assign bus.wait_cycles = wait_q;

endmodule

// File: doc/control_register_staged.md
Name: control_register_staged

Overview:
Parametrised successor to the single-stage microinstruction control register. Captures the control word from the microstore and its state number through a configurable pipeline of STAGES registers. Adds stall, flush-to-NOP and valid tracking. Adds a memory-operation wait: the pipeline freezes while the output word requests memory and MOC is low. Sits between the microstore and the datapath/next-state logic.

Parameters:
WORD_WIDTH, 38, control word width
STATE_WIDTH, 10, microstore state number width
STAGES, 1, pipeline depth (legal range 1..4)
WAIT_BIT, 30, bit index in the word that marks a memory access needing MOC
NOP_WORD, 0, word driven while flushed, reset or invalid
CNT_WIDTH, 8, wait-cycle counter width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
in  input  WORD_WIDTH  control word from microstore
in_state  input  STATE_WIDTH  state number of in
in_valid  input  1  in is a real microinstruction
stall  input  1  external freeze request
flush  input  1  discard all stages
moc  input  1  memory operation complete
cr  output  WORD_WIDTH  output-stage control word
cr_state  output  STATE_WIDTH  output-stage state number
cr_valid  output  1  output-stage valid
busy  output  1  pipeline held waiting for moc
wait_cycles  output  CNT_WIDTH  consecutive cycles busy, saturating

Behaviour:
- Each stage holds word, state and valid. Stage 0 is the input stage; stage STAGES-1 drives cr and cr_state.
- wait_hold = cr_valid & cr[WAIT_BIT] & ~moc. busy = wait_hold, combinational.
- advance = ~stall & ~wait_hold.
- Priority per edge: reset > flush > advance > hold.
- On reset or flush:
  - every stage word = NOP_WORD, state = 0, valid = 0;
  - wait_cycles = 0.
- On advance:
  - stage0 <= {in, in_state, in_valid};
  - stage i <= stage i-1;
  - the output stage is overwritten.
- On hold, all stages keep their values. in is ignored (not queued); the upstream sequencer must also hold.
- cr = NOP_WORD whenever cr_valid = 0, even if the stage word register differs. cr_state = 0 when invalid.
- Latency: a word presented with in_valid on an advancing edge appears on cr after exactly STAGES advancing edges. Non-advancing edges add delay one-for-one.
- wait_cycles:
  - increments on each edge where wait_hold = 1;
  - saturates at all-ones;
  - clears to 0 on any edge where wait_hold = 0.
- moc high in the same cycle as a WAIT_BIT word reaching cr: no hold, advance proceeds if stall = 0.
- stall and wait_hold together: hold. wait_cycles still counts.
- Flush during wait: clears immediately; busy drops next cycle because cr_valid = 0.
- Reset mid-wait behaves as flush.
- WAIT_BIT must be < WORD_WIDTH; elaboration error otherwise.
- Invalid words never assert busy, even if NOP_WORD has WAIT_BIT set.

Test Plan:
1. Reset then pipeline fill (STAGES=2): reset=1 for 2 cycles → cr=0, cr_valid=0, busy=0, wait_cycles=0. Apply in=38'h0000000ABC, in_state=4, valid=1 → cr=38'h0000000ABC, cr_state=4, cr_valid=1 after 2 edges.
2. Stall (STAGES=1): in sequence states 4, 20; stall=1 for 3 cycles after state 4 is captured → cr_state stays 4 for 3 cycles. State 20 appears on the first edge after stall drops.
3. MOC wait: word with bit 30 set reaches cr, moc=0 for 5 cycles → busy=1, wait_cycles counts 1..5, cr frozen. moc=1 → advance on that edge, wait_cycles=0 next cycle. CNT_WIDTH=3 with 10 wait cycles → wait_cycles saturates at 7.
4. Same-cycle MOC: WAIT_BIT word arrives with moc already 1 → busy never asserts, no extra latency.
5. Flush priority: flush=1 with stall=1 and busy=1 → next cycle all stages invalid, cr=NOP_WORD, busy=0. Test also with NOP_WORD=38'h3F: output cr=38'h3F.
6. Reset mid-wait: busy=1, wait_cycles=3, assert reset → next cycle cr_valid=0, wait_cycles=0. A new word after reset appears with normal latency.
